// File: rtl/ifu_axi_prefetch.sv
// ifu_axi_prefetch: AXI-Lite instruction prefetcher with one outstanding read and a small PC/instruction FIFO.
module ifu_axi_prefetch #(
    parameter int                ADDR_W   = 32,
    parameter int                DATA_W   = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = 32'h8000_0000,
    parameter int                DEPTH    = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              redirect_valid,
    input  logic [ADDR_W-1:0] redirect_pc,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ADDR_W-1:0] out_pc,
    output logic [DATA_W-1:0] out_ins,
    output logic              out_fault,
    output logic [ADDR_W-1:0] araddr,
    output logic              arvalid,
    input  logic              arready,
    input  logic [DATA_W-1:0] rdata,
    input  logic [1:0]        rresp,
    input  logic              rvalid,
    output logic              rready
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    typedef enum logic [1:0] {IDLE, AR, R, DROP} state_t;

    state_t            state, state_d;
    logic [ADDR_W-1:0] fetch_pc, fetch_pc_d, cap_addr;
    logic              halt, drop_mark;
    logic [PW-1:0]     wr_ptr, rd_ptr;
    logic [CW-1:0]     count, count_d;
    logic              push, pop, fault;
    logic [ADDR_W-1:0] mem_pc [DEPTH];
    logic [DATA_W-1:0] mem_ins [DEPTH];
    logic              mem_fault [DEPTH];

    assign fault      = rresp != 2'b00;
    assign push       = state == R && rvalid && !redirect_valid;
    assign pop        = out_valid && out_ready && !redirect_valid;
    assign count_d    = redirect_valid ? '0 : count + CW'(push) - CW'(pop);
    assign fetch_pc_d = redirect_valid ? redirect_pc : (push && !fault) ? cap_addr + ADDR_W'(4) : fetch_pc;

    assign out_valid = count != '0;
    assign out_pc    = mem_pc[rd_ptr];
    assign out_ins   = mem_ins[rd_ptr];
    assign out_fault = mem_fault[rd_ptr];
    assign arvalid   = state == AR;
    assign rready    = state == R || state == DROP;
    // The address presented during AR is frozen even if a redirect moves fetch_pc.
    assign araddr    = state == AR ? cap_addr : fetch_pc;

    always_comb begin
        state_d = state;
        case (state)
            IDLE: state_d = (!redirect_valid && !halt && count < CW'(DEPTH)) ? AR : IDLE;
            AR:   state_d = !arready ? AR : (drop_mark || redirect_valid) ? DROP : R;
            R:    state_d = rvalid ? ((push && !fault && count_d < CW'(DEPTH)) ? AR : IDLE)
                                   : redirect_valid ? DROP : R;
            DROP: state_d = rvalid ? IDLE : DROP;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            fetch_pc  <= RESET_PC;
            cap_addr  <= RESET_PC;
            halt      <= 1'b0;
            drop_mark <= 1'b0;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
        end else begin
            state     <= state_d;
            fetch_pc  <= fetch_pc_d;
            cap_addr  <= (state_d == AR && state != AR) ? fetch_pc_d : cap_addr;
            halt      <= redirect_valid ? 1'b0 : (push && fault) ? 1'b1 : halt;
            drop_mark <= state == AR && state_d == AR && (drop_mark || redirect_valid);
            wr_ptr    <= redirect_valid ? '0 : wr_ptr + PW'(push);
            rd_ptr    <= redirect_valid ? '0 : rd_ptr + PW'(pop);
            count     <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_pc[wr_ptr]    <= cap_addr;
            mem_ins[wr_ptr]   <= fault ? '0 : rdata;
            mem_fault[wr_ptr] <= fault;
        end
    end
endmodule
